uart_tx_arbiter: RTL and testbench

- Shares one UART transmitter among NUM_REQ requesters using a round-robin policy.
- Per frame:
  - latches the winning requester's data;
  - issues a one-cycle tx_start to the transmitter;
  - waits for tx_done;
  - returns a one-cycle ack to the winning requester.
- Sits between client logic and the transmitter. Drives the transmitter's tx_start/din and consumes its tx_done.
- Baud tick generation is outside this block.

---
 rtl/uart_tx_arbiter.sv | 172 +++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
//   Round-robin arbiter sharing one UART transmitter among NUM_REQ requesters.
//   Per frame: latch the winner's payload, pulse tx_start, wait for tx_done,
//   then pulse ack to the winner. All outputs are registered.
//
// Ports
//   clk       system clock, rising edge
//   rst       asynchronous active-low reset
//   req       per-requester frame request (level)
//   req_data  packed payloads, requester i at [i*DATA_W +: DATA_W]
//   ack       one-cycle completion pulse to the owner
//   gnt       one-hot owner, held from START through ACK
//   busy      high whenever not IDLE
//   tx_start  one-cycle start pulse to the transmitter
//   din       latched payload, stable from START until the next START
//   tx_done   frame-complete from the transmitter (pulse or level)
//   err       one-cycle watchdog timeout pulse
//
// Build option
//   UART_ARB_TIMEOUT_EN  builds the WAIT watchdog (TIMEOUT_CYC cycles).
//                        Undefined: no watchdog, err is constant 0.
//
// state   | meaning
// --------+---------------------------------------------------------
// S_IDLE  | no owner; pick a round-robin winner when any req is set
// S_START | tx_start pulse; tx_done ignored (may be stale)
// S_WAIT  | waiting for tx_done (or watchdog expiry)
// S_ACK   | ack pulse to owner; pointer moves past owner
module uart_tx_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int DATA_W      = 3,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ*DATA_W-1:0]  req_data,
  output logic [NUM_REQ-1:0]         ack,
  output logic [NUM_REQ-1:0]         gnt,
  output logic                       busy,
  output logic                       tx_start,
  output logic [DATA_W-1:0]          din,
  input  logic                       tx_done,
  output logic                       err
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT, S_ACK} state_t;

  state_t              state, state_nxt;
  logic [IDX_W-1:0]    ptr, ptr_nxt;
  logic [IDX_W-1:0]    owner, owner_nxt, owner_inc;
  logic [IDX_W-1:0]    win;
  logic                win_vld;
  logic                timeout;
  logic                wdog_tc;
  logic [NUM_REQ-1:0]  gnt_nxt, ack_nxt;
  logic [DATA_W-1:0]   din_nxt;
  logic                busy_nxt, tx_start_nxt, err_nxt;
  logic [DATA_W-1:0]   data_arr [NUM_REQ];
  int                  idx;

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      data_arr[i] = req_data[i*DATA_W +: DATA_W];
    end
  end

  // First set request at or above ptr, wrapping around.
  always_comb begin
    win     = '0;
    win_vld = 1'b0;
    idx     = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(ptr) + k) % NUM_REQ;
      if (!win_vld && req[IDX_W'(idx)]) begin
        win     = IDX_W'(idx);
        win_vld = 1'b1;
      end
    end
  end

  assign owner_inc = (owner == IDX_W'(NUM_REQ - 1)) ? '0 : owner + 1'b1;

`ifdef UART_ARB_TIMEOUT_EN
  localparam int WD_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  logic [WD_W-1:0] wdog;

  // Loaded during START so the first WAIT cycle holds TIMEOUT_CYC-1;
  // reaching zero without tx_done means TIMEOUT_CYC-1 WAIT cycles elapsed.
  assign wdog_tc = (wdog == '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wdog <= '0;
    end else if (state == S_START) begin
      wdog <= WD_W'(TIMEOUT_CYC - 1);
    end else if (state == S_WAIT && !wdog_tc) begin
      wdog <= wdog - 1'b1;
    end
  end
`else
  assign wdog_tc = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_IDLE;
      ptr      <= '0;
      owner    <= '0;
      gnt      <= '0;
      ack      <= '0;
      din      <= '0;
      busy     <= 1'b0;
      tx_start <= 1'b0;
      err      <= 1'b0;
    end else begin
      state    <= state_nxt;
      ptr      <= ptr_nxt;
      owner    <= owner_nxt;
      gnt      <= gnt_nxt;
      ack      <= ack_nxt;
      din      <= din_nxt;
      busy     <= busy_nxt;
      tx_start <= tx_start_nxt;
      err      <= err_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    timeout   = 1'b0;
    case (state)
      S_IDLE:  if (win_vld) state_nxt = S_START;
      S_START: state_nxt = S_WAIT;
      S_WAIT: begin
        if (tx_done) begin
          state_nxt = S_ACK;
        end else if (wdog_tc) begin
          state_nxt = S_IDLE;
          timeout   = 1'b1;
        end
      end
      S_ACK:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they appear registered
  // in the same cycle the FSM enters the corresponding state.
  always_comb begin
    gnt_nxt   = gnt;
    din_nxt   = din;
    owner_nxt = owner;
    ptr_nxt   = ptr;
    ack_nxt   = '0;
    if (state == S_IDLE && state_nxt == S_START) begin
      gnt_nxt   = NUM_REQ'(1) << win;
      din_nxt   = data_arr[win];
      owner_nxt = win;
    end else if (state_nxt == S_IDLE) begin
      gnt_nxt = '0;
    end
    if (state_nxt == S_ACK) ack_nxt = gnt;
    if (state == S_ACK || timeout) ptr_nxt = owner_inc;
    tx_start_nxt = (state_nxt == S_START);
    busy_nxt     = (state_nxt != S_IDLE);
    err_nxt      = timeout;
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: reset values, directed frame
// sequences, a table of single-frame vectors and a randomized run against
// a transaction-level reference model.
module tb_uart_tx_arbiter;

  logic        clk;
  logic        rst;
  logic [3:0]  req;
  logic [11:0] req_data;
  logic [3:0]  ack;
  logic [3:0]  gnt;
  logic        busy;
  logic        tx_start;
  logic [2:0]  din;
  logic        tx_done;
  logic        err;

  int total = 0;
  int bad   = 0;

  uart_tx_arbiter #(.NUM_REQ(4), .DATA_W(3), .TIMEOUT_CYC(16)) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .req_data (req_data),
    .ack      (ack),
    .gnt      (gnt),
    .busy     (busy),
    .tx_start (tx_start),
    .din      (din),
    .tx_done  (tx_done),
    .err      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic apply_reset();
    req     = '0;
    tx_done = 1'b0;
    rst     = 1'b0;
    tick();
    tick();
    rst = 1'b1;
  endtask

  task automatic wait_start(input string name, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      tick();
      if (tx_start) ok = 1'b1;
    end
    if (!ok) begin
      total++;
      bad++;
      $display("FAIL %s: got no tx_start expected one within 40 cycles", name);
    end
  endtask

  // Serves one frame: tx_done pulsed `delay` cycles after START, optional
  // stale tx_done during START. Returns in the IDLE cycle after ACK.
  task automatic run_frame(input string name, input int delay, input bit stale,
                           input logic [3:0] exp_gnt, input logic [2:0] exp_din);
    bit ok;
    wait_start(name, ok);
    if (!ok) return;
    chk({name, " gnt"}, gnt, exp_gnt);
    chk({name, " din"}, din, exp_din);
    chk({name, " busy@start"}, busy, 1);
    chk({name, " err@start"}, err, 0);
    if (stale) tx_done = 1'b1;
    for (int k = 1; k <= delay; k++) begin
      tick();
      tx_done = 1'b0;
      chk({name, " tx_start width"}, tx_start, 0);
      chk({name, " early ack"}, ack, 0);
      chk({name, " gnt held"}, gnt, exp_gnt);
      if (k == delay) tx_done = 1'b1;
    end
    tick();
    tx_done = 1'b0;
    chk({name, " ack"}, ack, exp_gnt);
    chk({name, " gnt@ack"}, gnt, exp_gnt);
    chk({name, " busy@ack"}, busy, 1);
    tick();
    chk({name, " ack width"}, ack, 0);
    chk({name, " gnt@idle"}, gnt, 0);
    chk({name, " busy@idle"}, busy, 0);
  endtask

  function automatic int rr_pick(input logic [3:0] r, input int p);
    for (int k = 0; k < 4; k++) begin
      if (r[(p + k) % 4]) return (p + k) % 4;
    end
    return -1;
  endfunction

  typedef struct {
    logic [3:0]  req;
    logic [11:0] data;
    logic [3:0]  gnt;
    logic [2:0]  din;
  } vec_t;

  vec_t tbl[9];

  initial begin
    bit ok;
    logic [2:0]  dat [4];
    logic [3:0]  rel;
    logic [3:0]  req_prev;
    logic [11:0] data_prev;
    logic        done_prev;
    logic        stale;
    bit          act, exp_start, exp_ack;
    int          ptr_m, owner, start_t, ack_t, done_at;
    logic [2:0]  din_m;

    // Table vectors: run back to back from reset, each requester drops
    // its request after the frame; expectations follow the pointer chain.
    tbl[0] = '{4'b0001, {3'd0, 3'd0, 3'd0, 3'd5}, 4'b0001, 3'd5}; // ptr0
    tbl[1] = '{4'b0101, {3'd0, 3'd6, 3'd0, 3'd3}, 4'b0100, 3'd6}; // ptr1
    tbl[2] = '{4'b0111, {3'd0, 3'd2, 3'd4, 3'd1}, 4'b0001, 3'd1}; // ptr3 wraps
    tbl[3] = '{4'b1000, {3'd7, 3'd0, 3'd0, 3'd0}, 4'b1000, 3'd7}; // ptr1
    tbl[4] = '{4'b1110, {3'd1, 3'd3, 3'd2, 3'd0}, 4'b0010, 3'd2}; // ptr0
    tbl[5] = '{4'b0011, {3'd0, 3'd0, 3'd5, 3'd4}, 4'b0001, 3'd4}; // ptr2 wraps
    tbl[6] = '{4'b1111, {3'd3, 3'd2, 3'd0, 3'd6}, 4'b0010, 3'd0}; // ptr1
    tbl[7] = '{4'b1100, {3'd3, 3'd3, 3'd0, 3'd0}, 4'b0100, 3'd3}; // ptr2
    tbl[8] = '{4'b1111, {3'd6, 3'd1, 3'd2, 3'd3}, 4'b1000, 3'd6}; // ptr3

    rst      = 1'b0;
    req      = '0;
    req_data = '0;
    tx_done  = 1'b0;
    tick();
    chk("reset gnt", gnt, 0);
    chk("reset ack", ack, 0);
    chk("reset tx_start", tx_start, 0);
    chk("reset busy", busy, 0);
    chk("reset err", err, 0);
    chk("reset din", din, 0);
    rst = 1'b1;

    // Single requester, slow transmitter.
    req      = 4'b0001;
    req_data = {3'd0, 3'd0, 3'd0, 3'd5};
    run_frame("single", 20, 1'b0, 4'b0001, 3'd5);
    req = '0;

    // Two simultaneous requests, then show ptr sits at 3.
    apply_reset();
    req      = 4'b0101;
    req_data = {3'd0, 3'd6, 3'd0, 3'd3};
    run_frame("pair first", 3, 1'b0, 4'b0001, 3'd3);
    req = 4'b0100;
    run_frame("pair second", 3, 1'b0, 4'b0100, 3'd6);
    req      = 4'b1001;
    req_data = {3'd1, 3'd0, 3'd0, 3'd2};
    run_frame("ptr after pair", 2, 1'b0, 4'b1000, 3'd1);
    req = '0;

    // All four held continuously for 8 frames.
    req      = 4'b1111;
    req_data = {3'd4, 3'd7, 3'd1, 3'd2};
    for (int f = 0; f < 8; f++) begin
      run_frame($sformatf("hold frame%0d", f), 1 + f % 3, 1'b0,
                4'b0001 << (f % 4), req_data[(f % 4) * 3 +: 3]);
    end
    req = '0;

    // tx_done high during START must be ignored.
    req      = 4'b0010;
    req_data = {3'd0, 3'd0, 3'd3, 3'd0};
    run_frame("stale done", 6, 1'b1, 4'b0010, 3'd3);
    req = '0;

    // Reset in the middle of WAIT.
    req      = 4'b0100;
    req_data = {3'd0, 3'd5, 3'd0, 3'd0};
    wait_start("abort", ok);
    tick();
    tick();
    #2 rst = 1'b0;
    #1;
    chk("abort gnt", gnt, 0);
    chk("abort busy", busy, 0);
    chk("abort din", din, 0);
    chk("abort tx_start", tx_start, 0);
    req      = 4'b0110;
    req_data = {3'd0, 3'd2, 3'd6, 3'd0};
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("abort ack", ack, 0);
      chk("abort busy held", busy, 0);
      chk("abort tx_start held", tx_start, 0);
    end
    rst = 1'b1;
    // ptr was reset to 0, so requester 1 beats requester 2.
    run_frame("after abort", 2, 1'b0, 4'b0010, 3'd6);
    req = '0;

`ifdef UART_ARB_TIMEOUT_EN
    // Transmitter never answers: watchdog fires 16 cycles after WAIT entry.
    req      = 4'b0011;
    req_data = {3'd0, 3'd0, 3'd4, 3'd1};
    wait_start("timeout", ok);
    chk("timeout gnt", gnt, 4'b0001);
    for (int k = 1; k <= 16; k++) begin
      tick();
      chk("timeout early err", err, 0);
      chk("timeout busy", busy, 1);
      chk("timeout ack", ack, 0);
    end
    tick();
    chk("timeout err", err, 1);
    chk("timeout busy after", busy, 0);
    chk("timeout no ack", ack, 0);
    chk("timeout gnt after", gnt, 0);
    run_frame("after timeout", 2, 1'b0, 4'b0010, 3'd4);
    req = '0;
`else
    // Without the watchdog, WAIT persists until tx_done.
    req      = 4'b0001;
    req_data = {3'd0, 3'd0, 3'd0, 3'd2};
    wait_start("long wait", ok);
    for (int k = 0; k < 40; k++) begin
      tick();
      chk("long wait busy", busy, 1);
      chk("long wait ack", ack, 0);
      chk("long wait err", err, 0);
    end
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    chk("long wait ack", ack, 4'b0001);
    tick();
    req = '0;
`endif

    // Table vectors from a fresh reset.
    apply_reset();
    for (int i = 0; i < 9; i++) begin
      req      = tbl[i].req;
      req_data = tbl[i].data;
      run_frame($sformatf("vec%0d", i), 2, 1'b0, tbl[i].gnt, tbl[i].din);
      req = '0;
    end

    // Randomized traffic against a frame-level reference model.
    apply_reset();
    ptr_m     = 0;
    act       = 1'b0;
    owner     = 0;
    start_t   = -10;
    ack_t     = -10;
    done_at   = -10;
    din_m     = '0;
    rel       = '0;
    req_prev  = '0;
    data_prev = '0;
    done_prev = 1'b0;
    stale     = 1'b0;
    for (int i = 0; i < 4; i++) dat[i] = '0;
    for (int u = 0; u < 3000; u++) begin
      tick();
      exp_start = 1'b0;
      exp_ack   = 1'b0;
      if (!act) begin
        if (req_prev != 0) begin
          owner     = rr_pick(req_prev, ptr_m);
          act       = 1'b1;
          start_t   = u;
          din_m     = data_prev[owner * 3 +: 3];
          exp_start = 1'b1;
        end
      end else if (ack_t == u - 1) begin
        act   = 1'b0;
        ptr_m = (owner + 1) % 4;
      end else if (u - 1 > start_t && done_prev) begin
        exp_ack = 1'b1;
        ack_t   = u;
      end

      chk("rnd tx_start", tx_start, exp_start);
      chk("rnd ack", ack, exp_ack ? (32'd1 << owner) : 32'd0);
      chk("rnd gnt", gnt, act ? (32'd1 << owner) : 32'd0);
      chk("rnd busy", busy, act);
      chk("rnd din", din, din_m);
      chk("rnd err", err, 0);

      if (exp_start) begin
        done_at = u + $urandom_range(1, 6);
        stale   = ($urandom_range(0, 3) == 0);
      end
      tx_done = (u == done_at) || (exp_start && stale);
      for (int i = 0; i < 4; i++) begin
        if (exp_ack && owner == i) begin
          rel[i] = 1'b1;
        end else if (rel[i]) begin
          rel[i] = 1'b0;
          if ($urandom_range(0, 1) == 1) dat[i] = 3'($urandom_range(0, 7));
          else req[i] = 1'b0;
        end else if (!req[i]) begin
          dat[i] = 3'($urandom_range(0, 7));
          if ($urandom_range(0, 3) == 0) req[i] = 1'b1;
        end
      end
      req_data  = {dat[3], dat[2], dat[1], dat[0]};
      req_prev  = req;
      data_prev = req_data;
      done_prev = tx_done;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
